// File: rtl/chip_pkg.sv
// rtl/chip_pkg.sv - shared constants and helpers for the chip word packer
package chip_pkg;

  localparam int NIB_W_DEF     = 4;
  localparam int WORD_W_DEF    = 32;
  localparam int NUM_LANES_DEF = 2;

  function automatic int beats_f(input int word_w, input int nib_w);
    return word_w / nib_w;
  endfunction

  // One extra bit so the count can also express a full word (BEATS)
  localparam int BEAT_CNT_W_DEF = $clog2(beats_f(WORD_W_DEF, NIB_W_DEF)) + 1;
  typedef logic [BEAT_CNT_W_DEF-1:0] beat_cnt_t;

endpackage

// File: rtl/chip_lane_accum.sv
// rtl/chip_lane_accum.sv - one lane's word accumulator with write-at-index and clear
module chip_lane_accum
  import chip_pkg::*;
#(
  parameter int NIB_W  = NIB_W_DEF,
  parameter int WORD_W = WORD_W_DEF,
  parameter int IDX_W  = BEAT_CNT_W_DEF
) (
  input  logic              pclk,
  input  logic              RESET_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [NIB_W-1:0]  wr_data,
  input  logic              clr,
  output logic [WORD_W-1:0] acc_next
);

  localparam int BEATS = beats_f(WORD_W, NIB_W);

  logic [WORD_W-1:0] acc;

  // acc_next includes this cycle's beat so a completing word can be loaded directly
  always_comb begin
    acc_next = acc;
    if (wr_en) begin
      for (int b = 0; b < BEATS; b++) begin
        if (wr_idx == IDX_W'(b)) acc_next[b*NIB_W +: NIB_W] = wr_data;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!RESET_n)  acc <= '0;
    else if (clr)  acc <= '0;
    else           acc <= acc_next;
  end

endmodule

// File: rtl/chip_word_packer.sv
// rtl/chip_word_packer.sv - NUM_LANES nibble-to-word packer with flush; CHIP_PARITY_EN adds out_parity
module chip_word_packer
  import chip_pkg::*;
#(
  parameter int NIB_W     = NIB_W_DEF,
  parameter int WORD_W    = WORD_W_DEF,
  parameter int NUM_LANES = NUM_LANES_DEF
) (
  input  logic                          pclk,
  input  logic                          RESET_n,
  input  logic                          pValid,
  output logic                          pReady,
  input  logic [NUM_LANES*NIB_W-1:0]    nib_data,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_LANES*WORD_W-1:0]   chip_value,
  output logic [$clog2(WORD_W/NIB_W):0] out_beats
`ifdef CHIP_PARITY_EN
  ,
  output logic [NUM_LANES-1:0]          out_parity
`endif
);

  localparam int BEATS = beats_f(WORD_W, NIB_W);
  localparam int CNT_W = $clog2(BEATS) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0]            beat_cnt;
  logic [CNT_W-1:0]            filled;
  logic                        held;
  logic                        last_beat;
  logic                        accept;
  logic                        close_word;
  logic                        load;
  logic [NUM_LANES*WORD_W-1:0] word_next;

  // Only a beat or flush that would close the word must wait for a held output
  assign held       = out_valid && !out_ready;
  assign last_beat  = (beat_cnt == LAST_IDX);
  assign pReady     = !(held && (last_beat || flush));
  assign accept     = pValid && pReady;
  assign filled     = beat_cnt + CNT_W'(accept);
  assign close_word = (accept && last_beat) || (flush && (filled != '0));
  assign load       = close_word && !held;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    chip_lane_accum #(
      .NIB_W  (NIB_W),
      .WORD_W (WORD_W),
      .IDX_W  (CNT_W)
    ) u_accum (
      .pclk     (pclk),
      .RESET_n  (RESET_n),
      .wr_en    (accept),
      .wr_idx   (beat_cnt),
      .wr_data  (nib_data[i*NIB_W +: NIB_W]),
      .clr      (load),
      .acc_next (word_next[i*WORD_W +: WORD_W])
    );
  end

  always_ff @(posedge pclk) begin
    if (!RESET_n)     beat_cnt <= '0;
    else if (load)    beat_cnt <= '0;
    else if (accept)  beat_cnt <= beat_cnt + CNT_W'(1);
  end

  always_ff @(posedge pclk) begin
    if (!RESET_n) begin
      out_valid  <= 1'b0;
      chip_value <= '0;
      out_beats  <= '0;
    end else if (load) begin
      out_valid  <= 1'b1;
      chip_value <= word_next;
      out_beats  <= filled;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

`ifdef CHIP_PARITY_EN
  logic [NUM_LANES-1:0] parity_next;

  always_comb begin
    parity_next = '0;
    for (int i = 0; i < NUM_LANES; i++) parity_next[i] = ^word_next[i*WORD_W +: WORD_W];
  end

  always_ff @(posedge pclk) begin
    if (!RESET_n)   out_parity <= '0;
    else if (load)  out_parity <= parity_next;
  end
`else
  // Parity output compiled out; the datapath is unchanged.
`endif

endmodule

// File: doc/chip_word_packer.md
Name: chip_word_packer

Overview:
- Parametrised nibble-to-word packer for the chip datapath. It generalises the fixed two-lane (LSB/MSB) 4-bit-to-32-bit chip value assembly to NUM_LANES lanes, NIB_W-bit input beats and WORD_W-bit output words.
- Upstream side uses a pValid/pReady handshake. Downstream side presents one registered word per lane with an out_valid/out_ready handshake.
- A flush input closes a partial word early, zero-padding the bits that were not filled.

Parameters:
- NIB_W, default 4: bits per lane per accepted beat.
- WORD_W, default 32: output word width per lane. Must be a multiple of NIB_W.
- NUM_LANES, default 2: number of parallel lanes. Lane 0 corresponds to the old LSB lane, lane 1 to the old MSB lane.

Ports:
- pclk, input, 1: clock; everything updates on its rising edge.
- RESET_n, input, 1: synchronous active-low reset.
- pValid, input, 1: upstream beat valid.
- pReady, output, 1: packer can accept a beat.
- nib_data, input, NUM_LANES*NIB_W: lane i occupies bits [i*NIB_W +: NIB_W].
- flush, input, 1: close the current partial word.
- out_valid, output, 1: chip_value holds a complete word.
- out_ready, input, 1: downstream accepts the word.
- chip_value, output, NUM_LANES*WORD_W: lane i occupies bits [i*WORD_W +: WORD_W].
- out_beats, output, $clog2(WORD_W/NIB_W)+1: number of real beats contained in chip_value.

Behaviour:
- Derived constant: BEATS = WORD_W/NIB_W.
- Internal state: per-lane accumulator (WORD_W bits) and a shared beat_cnt (0..BEATS-1).
- Reset (RESET_n low at an edge): accumulators, beat_cnt, chip_value, out_beats and out_valid all go to 0.
  - pReady is combinational and reads 1 out of reset.
  - Reset mid-word discards the partial word and any held output word.
- Upstream acceptance: a beat is accepted when pValid && pReady. On acceptance, lane i writes nib_data lane i into accumulator bits [beat_cnt*NIB_W +: NIB_W]. The first beat lands in the LSBs.
- Word completion: the word completes when an accepted beat has beat_cnt == BEATS-1.
  - The next cycle, chip_value shows the full words, out_beats = BEATS and out_valid = 1.
  - Latency from the last accepted beat to out_valid is 1 cycle.
  - Accumulators and beat_cnt clear in the same edge that loads chip_value.
- Flush:
  - flush high with beat_cnt > 0 (counting the current cycle's accepted beat, if any, as included) closes the word. Unfilled bits are 0 and out_beats = the number of filled beats. Same 1-cycle latency.
  - flush with nothing accumulated and no beat accepted is ignored.
  - A flush that cannot load because the output is held stays pending until the output is consumed. The upstream must hold flush; it is level-sensitive.
- Output hold: chip_value, out_beats and out_valid stay stable while out_valid && !out_ready. out_valid && out_ready clears out_valid unless a new word loads on the same edge; in that case out_valid stays 1 with the new data, giving no bubble.
- pReady = !(out_valid && !out_ready && (beat_cnt == BEATS-1 || flush)).
  - Non-final beats are accepted even while the output is held.
  - pReady never depends on pValid.
- Simultaneous flush and final beat: this is a single word with out_beats = BEATS.
- beat_cnt wraps from BEATS-1 to 0 only on word completion.

Optional Feature:
- Macro CHIP_PARITY_EN.
- When defined: an extra output out_parity, NUM_LANES bits wide.
  - Bit i is the even parity (XOR) of lane i of chip_value.
  - It is registered together with chip_value, held under the same rules, and resets to 0.
- When undefined: the port and its logic are absent. Nothing else changes.

Decomposition:
- Package chip_pkg holds:
  - default NIB_W/WORD_W/NUM_LANES constants;
  - function beats_f(WORD_W, NIB_W);
  - typedef for the beat counter width.
- Sub-module chip_lane_accum holds one lane's accumulator with write-at-index and clear. It is instantiated NUM_LANES times in a generate loop. beat_cnt, the handshakes and the output register stay in the top.

Test Plan:
- Reset, then defaults. Lane0 gets nibbles 1,2,...,8 and lane1 gets F,E,...,8 on 8 consecutive beats with out_ready=1.
  - Required: lane0 = 0x87654321, lane1 = 0x89ABCDEF, out_valid one cycle after beat 8, out_beats = 8, pReady constantly 1.
- out_ready=0 and 16 beats streamed.
  - Required: first word held stable; beats 9-15 accepted; pReady=0 at beat 16 until out_ready=1, then the second word follows with no bubble.
- 3 beats (1,2,3) then flush.
  - Required: lane0 = 0x00000321, out_beats = 3, beat_cnt back to 0.
  - A flush on the next idle cycle produces nothing.
- flush asserted together with the 8th beat.
  - Required: one word with out_beats = 8; no extra empty word.
- RESET_n low for 1 cycle after 5 beats, then 8 fresh beats.
  - Required: out_valid=0 during reset; the next word contains only the fresh 8 beats.
- CHIP_PARITY_EN defined, lane0 word 0x00000001.
  - Required: out_parity[0] = 1.
  - Lane0 word 0x00000003 gives out_parity[0] = 0.
